// File: rtl/frame_reader.sv
// Frame reader: streams NUM_WORDS memory words into a credit-limited FIFO.
// Define FRAME_READER_LOOP_EN to re-read the frame continuously after start.
module frame_reader #(
  parameter int DATA_W     = 18,
  parameter int ADDR_W     = 9,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_wr_busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]  L_LAST  = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  L_DEPTH = CNT_W'(FIFO_DEPTH);

  if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W)) begin : g_bad_nw
    $error("frame_reader: NUM_WORDS out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("frame_reader: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_buf [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_inflight;
  logic              r_done;

  logic              w_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_used;

  // Credit counts words already buffered plus the one still on the bus.
  assign w_used  = r_cnt + CNT_W'(r_inflight);
  assign w_rd    = (r_state == S_FETCH) && !mem_wr_busy
                   && (w_used < L_DEPTH);
  assign w_empty = (r_cnt == '0);
  assign w_push  = r_inflight;
  assign w_pop   = !w_empty && pix_ready;

  assign rd_en      = w_rd;
  assign rd_addr    = L_BASE + r_idx[ADDR_W-1:0];
  assign pix_valid  = !w_empty;
  assign pix_data   = w_empty ? '0 : r_buf[r_rptr];
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_rd) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == L_LAST) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty && !r_inflight) begin
            r_done <= 1'b1;
`ifdef FRAME_READER_LOOP_EN
            r_idx   <= '0;
            r_state <= S_FETCH;
`else
            r_state <= S_IDLE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Randomised bench for frame_reader against a queue-based reference model.
module tb_frame_reader;

  localparam int DW    = 18;
  localparam int AW    = 9;
  localparam int BASE  = 510;
  localparam int DEPTH = 4;
  localparam int MSZ   = 1 << AW;
`ifdef FRAME_READER_LOOP_EN
  localparam int NW = 2;
`else
  localparam int NW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mem_wr_busy = 1'b0;
  logic          pix_ready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          busy;
  logic          frame_done;

  frame_reader #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE),
    .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_wr_busy(mem_wr_busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MSZ];
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int checks = 0;
  int errors = 0;

  bit            m_active, m_done, m_infl;
  int            m_issued, m_infl_addr, popped;
  int            obs_rd, obs_done;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] got_q[$];
  int            addr_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rd();
    return m_active && m_issued < NW && !mem_wr_busy
           && (m_q.size() + int'(m_infl)) < DEPTH;
  endfunction

  task automatic model_clear();
    m_active = 0; m_done = 0; m_infl = 0;
    m_issued = 0; popped = 0;
    m_q.delete();
  endtask

  task automatic step();
    bit rd, pop, fin;
    logic [DW-1:0] head;
    @(negedge clk);
    head = (m_q.size() > 0) ? m_q[0] : '0;
    if (rd_en) obs_rd++;
    if (frame_done) obs_done++;
    chk("busy", busy, m_active);
    chk("rd_en", rd_en, exp_rd());
    if (m_active && m_issued < NW)
      chk("rd_addr", rd_addr, (BASE + m_issued) % MSZ);
    chk("pix_valid", pix_valid, m_q.size() > 0);
    chk("pix_data", pix_data, head);
    chk("frame_done", frame_done, m_done);
    @(posedge clk);
    rd  = exp_rd();
    pop = m_q.size() > 0 && pix_ready;
    fin = m_active && m_issued == NW && m_q.size() == 0 && !m_infl;
    if (pop) begin
      got_q.push_back(m_q.pop_front());
      popped++;
    end
    if (m_infl) m_q.push_back(mem[m_infl_addr]);
    m_infl = rd;
    if (rd) begin
      m_infl_addr = (BASE + m_issued) % MSZ;
      addr_q.push_back(m_infl_addr);
      m_issued++;
    end
    m_done = fin;
    if (fin) begin
`ifdef FRAME_READER_LOOP_EN
      m_issued = 0;
`else
      m_active = 0;
`endif
    end else if (!m_active && start) begin
      m_active = 1;
      m_issued = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rd_addr", rd_addr, BASE % MSZ);
    chk("rst_pix_data", pix_data, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_idle(int bound);
    int n = 0;
    while (m_active && n < bound) begin
      step();
      n++;
    end
    chk("timeout", m_active, 0);
    step();
    step();
  endtask

  task automatic kick();
    got_q.delete();
    addr_q.delete();
    popped = 0;
    obs_rd = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_addrs();
    int e_addr[4] = '{510, 511, 0, 1};
    chk("addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      chk("addr_seq", addr_q[i], e_addr[i]);
  endtask

  initial begin
    for (int a = 0; a < MSZ; a++) mem[a] = DW'(a + 'h100);
    do_reset();
    step();
    step();
`ifdef FRAME_READER_LOOP_EN
    pix_ready = 1'b1;
    obs_done = 0;
    kick();
    for (int i = 0; i < 40; i++) begin
      start = ($urandom_range(0, 7) == 0);
      step();
    end
    start = 1'b0;
    chk("loop_done_pulses", obs_done > 4, 1);
    chk("loop_still_busy", busy, 1);
    do_reset();
    step();
`else
    pix_ready = 1'b1;
    kick();
    run_idle(50);
    chk("f1_words", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("f1_data", got_q[i], DW'(((BASE + i) % MSZ) + 'h100));
    chk_addrs();

    pix_ready = 1'b0;
    kick();
    repeat (10) step();
    chk("stall_reads", obs_rd, DEPTH);
    pix_ready = 1'b1;
    run_idle(50);
    chk("stall_words", got_q.size(), 4);

    kick();
    step();
    mem_wr_busy = 1'b1;
    repeat (3) step();
    mem_wr_busy = 1'b0;
    run_idle(50);
    chk_addrs();

    for (int a = 0; a < MSZ; a++) mem[a] = DW'($urandom);
    for (int f = 0; f < 6; f++) begin
      kick();
      for (int i = 0; i < 30; i++) begin
        pix_ready   = $urandom_range(0, 1);
        mem_wr_busy = ($urandom_range(0, 3) == 0);
        start       = ($urandom_range(0, 7) == 0);
        step();
      end
      start = 1'b0;
      pix_ready = 1'b1;
      mem_wr_busy = 1'b0;
      run_idle(60);
    end

    pix_ready = 1'b1;
    kick();
    for (int n = 0; popped < 2 && n < 20; n++) step();
    chk("pre_reset_popped", popped, 2);
    do_reset();
    repeat (3) step();
    kick();
    run_idle(50);
    chk_addrs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
